register_file: RTL and testbench

// 32-entry x N-bit architectural register file for the RV32 datapath, with two read ports and one write port.

---
 rtl/rv32_pkg.sv | 8 +
 rtl/register_file_if.sv | 36 +++
 rtl/decoder_5_to_32.sv | 10 +
 rtl/register_ena.sv | 20 ++
 rtl/register_file.sv | 63 ++++++
 tb/tb_register_file.sv | 186 ++++++++++++++++++
 6 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 register-file constants: register count, index width and the hardwired-zero index.
package rv32_pkg;

    localparam int              REG_COUNT  = 32;
    localparam int              REG_ADDR_W = 5;
    localparam logic [4:0]      ZERO_REG   = 5'd0;

endpackage

// File: rtl/register_file_if.sv
// Write port plus two combinational read ports of the architectural register file.
interface register_file_if
    import rv32_pkg::*;
#(
    parameter int N = 32
);

    logic                  wr_ena;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [N-1:0]          wr_data;
    logic [REG_ADDR_W-1:0] rd_addr0;
    logic [N-1:0]          rd_data0;
    logic [REG_ADDR_W-1:0] rd_addr1;
    logic [N-1:0]          rd_data1;

    modport master (
        output wr_ena,
        output wr_addr,
        output wr_data,
        output rd_addr0,
        output rd_addr1,
        input  rd_data0,
        input  rd_data1
    );

    modport slave (
        input  wr_ena,
        input  wr_addr,
        input  wr_data,
        input  rd_addr0,
        input  rd_addr1,
        output rd_data0,
        output rd_data1
    );

endinterface

// File: rtl/decoder_5_to_32.sv
// 5-to-32 one-hot decoder with enable; all outputs low when ena is low.
module decoder_5_to_32 (
    input  logic [4:0]  in,
    input  logic        ena,
    output logic [31:0] out
);

    assign out = ena ? (32'd1 << in) : 32'd0;

endmodule

// File: rtl/register_ena.sv
// N-bit register with load enable and asynchronous active-low clear.
module register_ena #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (ena) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_file.sv
// 32 x N register file, one write port and two combinational read ports, x0 hardwired to zero.
// Writes land one cycle later; BYPASS forwards a same-cycle write to matching read ports.
module register_file
    import rv32_pkg::*;
#(
    parameter int N      = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic     clk,
    input  logic     rst_n,
    register_file_if.slave bus
);

    logic [REG_COUNT-1:0] wr_en_oh;
    logic                 unused_en0;
    logic [N-1:0]         regs [REG_COUNT];
    logic                 fwd_vld;

    decoder_5_to_32 u_dec (
        .in  (bus.wr_addr),
        .ena (bus.wr_ena),
        .out (wr_en_oh)
    );

    // x0 has no storage, so its decoded enable goes nowhere.
    assign unused_en0 = wr_en_oh[ZERO_REG];
    assign regs[0]    = '0;

    generate
        for (genvar i = 1; i < REG_COUNT; i++) begin : g_reg
            register_ena #(.N(N)) u_reg (
                .clk   (clk),
                .rst_n (rst_n),
                .ena   (wr_en_oh[i]),
                .d     (bus.wr_data),
                .q     (regs[i])
            );
        end
    endgenerate

    // Forwarding is suppressed during reset so every port reads zero while rst_n is low.
    assign fwd_vld = BYPASS && rst_n && bus.wr_ena && (bus.wr_addr != ZERO_REG);

    function automatic logic [N-1:0] read_port(
        input logic [REG_ADDR_W-1:0] addr,
        input logic [N-1:0]          stored,
        input logic                  fwd,
        input logic [REG_ADDR_W-1:0] fwd_addr,
        input logic [N-1:0]          fwd_dat
    );
        if (addr == ZERO_REG) begin
            return '0;
        end
        if (fwd && (addr == fwd_addr)) begin
            return fwd_dat;
        end
        return stored;
    endfunction

    assign bus.rd_data0 = read_port(bus.rd_addr0, regs[bus.rd_addr0], fwd_vld, bus.wr_addr, bus.wr_data);
    assign bus.rd_data1 = read_port(bus.rd_addr1, regs[bus.rd_addr1], fwd_vld, bus.wr_addr, bus.wr_data);

endmodule

// File: tb/tb_register_file.sv
// Drives one bypassing and one non-bypassing register file with identical stimulus.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wr_ena = 1'b0;
    logic [4:0]  wr_addr = 5'd0;
    logic [31:0] wr_data = 32'd0;
    logic [4:0]  rd_addr0 = 5'd0;
    logic [4:0]  rd_addr1 = 5'd0;

    logic [31:0] model [32];
    int          n_tests = 0;
    int          n_fail  = 0;

    register_file_if #(.N(32)) if_b ();
    register_file_if #(.N(32)) if_n ();

    assign if_b.wr_ena   = wr_ena;
    assign if_b.wr_addr  = wr_addr;
    assign if_b.wr_data  = wr_data;
    assign if_b.rd_addr0 = rd_addr0;
    assign if_b.rd_addr1 = rd_addr1;
    assign if_n.wr_ena   = wr_ena;
    assign if_n.wr_addr  = wr_addr;
    assign if_n.wr_data  = wr_data;
    assign if_n.rd_addr0 = rd_addr0;
    assign if_n.rd_addr1 = rd_addr1;

    register_file #(.N(32), .BYPASS(1'b1)) dut_byp (.clk(clk), .rst_n(rst_n), .bus(if_b));
    register_file #(.N(32), .BYPASS(1'b0)) dut_nob (.clk(clk), .rst_n(rst_n), .bus(if_n));

    always #5 clk = ~clk;

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
    endtask

    // Expected read value from the architectural rules.
    function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] a);
        if (!rst_n || a == 5'd0) return 32'd0;
        if (byp && wr_ena && a == wr_addr) return wr_data;
        return model[a];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_ports(input string tag);
        check({tag, "_byp0"}, if_b.rd_data0, exp_rd(1'b1, rd_addr0));
        check({tag, "_byp1"}, if_b.rd_data1, exp_rd(1'b1, rd_addr1));
        check({tag, "_nob0"}, if_n.rd_data0, exp_rd(1'b0, rd_addr0));
        check({tag, "_nob1"}, if_n.rd_data1, exp_rd(1'b0, rd_addr1));
    endtask

    // From one negedge to the next, committing the write the edge performs.
    task automatic tick();
        @(posedge clk);
        if (rst_n && wr_ena && wr_addr != 5'd0) model[wr_addr] = wr_data;
        @(negedge clk);
    endtask

    task automatic scan_all(input string tag);
        for (int a = 0; a < 32; a++) begin
            rd_addr0 = 5'(a);
            rd_addr1 = 5'(31 - a);
            #1;
            check_ports(tag);
        end
    endtask

    initial begin
        clear_model();
        #1 rst_n = 1'b0;
        @(negedge clk);

        // 1: writes under reset are ignored
        wr_ena = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF; rd_addr0 = 5'd5; rd_addr1 = 5'd5;
        #1;
        check("rst_x5_byp", if_b.rd_data0, 32'd0);
        check("rst_x5_nob", if_n.rd_data0, 32'd0);
        tick();
        scan_all("rst_scan");
        rst_n = 1'b1; wr_ena = 1'b0;
        tick();
        rd_addr0 = 5'd5;
        #1;
        check("rel_x5", if_b.rd_data0, 32'd0);

        // 2: write latency and bypass
        wr_ena = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234_5678; rd_addr0 = 5'd7; rd_addr1 = 5'd0;
        #1;
        check("x7_T_byp", if_b.rd_data0, 32'h1234_5678);
        check("x7_T_nob", if_n.rd_data0, 32'd0);
        tick();
        wr_ena = 1'b0;
        #1;
        check("x7_T1_byp", if_b.rd_data0, 32'h1234_5678);
        check("x7_T1_nob", if_n.rd_data0, 32'h1234_5678);

        // 3: x0 stays zero
        wr_ena = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; rd_addr0 = 5'd0; rd_addr1 = 5'd0;
        #1;
        check("x0_pre_byp0", if_b.rd_data0, 32'd0);
        check("x0_pre_byp1", if_b.rd_data1, 32'd0);
        check("x0_pre_nob0", if_n.rd_data0, 32'd0);
        check("x0_pre_nob1", if_n.rd_data1, 32'd0);
        tick();
        wr_ena = 1'b0;
        #1;
        check("x0_post_byp", if_b.rd_data0, 32'd0);
        check("x0_post_nob", if_n.rd_data1, 32'd0);

        // 4: back-to-back writes, neighbour untouched
        wr_ena = 1'b1; wr_addr = 5'd31; wr_data = 32'hA5A5_A5A5; rd_addr0 = 5'd30; rd_addr1 = 5'd31;
        #1;
        check("x31_a_nob", if_n.rd_data1, 32'd0);
        check("x31_a_byp", if_b.rd_data1, 32'hA5A5_A5A5);
        tick();
        wr_data = 32'h5A5A_5A5A;
        #1;
        check("x31_b_nob", if_n.rd_data1, 32'hA5A5_A5A5);
        check("x31_b_byp", if_b.rd_data1, 32'h5A5A_5A5A);
        check("x30_b", if_b.rd_data0, 32'd0);
        tick();
        wr_ena = 1'b0;
        #1;
        check("x31_c_nob", if_n.rd_data1, 32'h5A5A_5A5A);
        check("x30_c", if_n.rd_data0, 32'd0);

        // 5: fill, then asynchronous reset mid-cycle
        for (int i = 1; i < 32; i++) begin
            wr_ena = 1'b1; wr_addr = 5'(i); wr_data = 32'(i) * 32'h0101_0101;
            tick();
        end
        wr_ena = 1'b0;
        scan_all("fill");
        rd_addr0 = 5'd17; rd_addr1 = 5'd31;
        #1;
        check("fill_x17", if_n.rd_data0, 32'h1111_1111);
        check("fill_x31", if_n.rd_data1, 32'h1F1F_1F1F);
        wr_ena = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFE_F00D; rd_addr0 = 5'd3; rd_addr1 = 5'd4;
        #1;
        check_ports("pre_rst");
        #1 rst_n = 1'b0;
        clear_model();
        #1;
        check("async_byp0", if_b.rd_data0, 32'd0);
        check("async_nob0", if_n.rd_data0, 32'd0);
        check("async_byp1", if_b.rd_data1, 32'd0);
        tick();
        rst_n = 1'b1; wr_ena = 1'b0;
        scan_all("post_rst");

        // 6: randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                clear_model();
            end
            wr_ena  = 1'($urandom_range(0, 1));
            wr_addr = 5'($urandom);
            wr_data = $urandom;
            rd_addr0 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
            rd_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
            #1;
            check_ports("rand");
            if (n_fail != 0) begin
                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                $fatal(1, "FAIL rand stopped at cycle %0d", c);
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
